// File: rtl/lcd_arb_pkg.sv
// Purpose: shared types and constants for the two-requester LCD write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_arb_pkg;

  localparam int NREQ            = 2;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    BUSY,
    ACK
  } arb_state_t;

endpackage

// File: rtl/lcd_rr_pick.sv
// Purpose: one-hot round-robin winner between two requesters, honouring a burst lock.
// Latency: combinational.
// Backpressure: none; a locked non-owner simply never wins.
module lcd_rr_pick
  import lcd_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            ptr,
  input  logic            lock,
  input  logic            owner,
  output logic [NREQ-1:0] winner
);

  // Locked: only the owner may win. Contended: the pointer (the requester not
  // served last) wins. Otherwise the single valid requester wins.
  always_comb begin
    winner = '0;
    if (lock) begin
      winner[owner] = valid[owner];
    end else if (&valid) begin
      winner[ptr] = 1'b1;
    end else begin
      winner = valid;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Purpose: serialises byte bursts from two requesters onto one LCD controller write port.
// Latency: 1 cycle from sampled req_valid to writeStart, 1 cycle from writeDone to ack.
// Backpressure: requesters hold req_valid/data until ack; optional watchdog via LCD_ARB_TIMEOUT_EN.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [7:0]      req_data0,
  input  logic [7:0]      req_data1,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] ack,
  input  logic            initDone,
  output logic            writeStart,
  output logic [7:0]      dataIn,
  input  logic            writeDone,
  output logic            timeout_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_t      state_q, state_n;
  logic [NREQ-1:0] grant_q, grant_n;
  logic [7:0]      data_q,  data_n;
  logic            last_q,  last_n;
  logic            lock_q,  lock_n;
  logic            ptr_q,   ptr_n;
  logic [NREQ-1:0] winner;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_n;
  logic          terr_q, terr_n;
  logic          counting;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  lcd_rr_pick u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .lock   (lock_q),
    .owner  (grant_q[1]),
    .winner (winner)
  );

  assign grant  = grant_q;
  assign dataIn = data_q;

  // Next-state, datapath capture and strobe outputs.
  always_comb begin
    state_n    = state_q;
    grant_n    = grant_q;
    data_n     = data_q;
    last_n     = last_q;
    lock_n     = lock_q;
    ptr_n      = ptr_q;
    writeStart = 1'b0;
    ack        = '0;
    case (state_q)
      WAIT_INIT: if (initDone) state_n = IDLE;
      IDLE: begin
        if (|winner) begin
          grant_n = winner;
          data_n  = winner[1] ? req_data1   : req_data0;
          last_n  = winner[1] ? req_last[1] : req_last[0];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        writeStart = 1'b1;
        state_n    = BUSY;
      end
      BUSY: if (writeDone) state_n = ACK;
      ACK: begin
        ack     = grant_q;
        state_n = IDLE;
        if (last_q) begin
          // Burst over: release and give the other requester priority.
          grant_n = '0;
          lock_n  = 1'b0;
          ptr_n   = ~grant_q[1];
        end else begin
          lock_n  = 1'b1;
        end
      end
      default: state_n = WAIT_INIT;
    endcase

`ifdef LCD_ARB_TIMEOUT_EN
    terr_n   = terr_q;
    counting = (state_q == BUSY) || ((state_q == IDLE) && lock_q);
    cnt_n    = '0;
    if (counting && (state_n == state_q)) begin
      if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        // Watchdog: abandon the owner without an ack and move priority on.
        terr_n  = 1'b1;
        grant_n = '0;
        lock_n  = 1'b0;
        ptr_n   = ~grant_q[1];
        state_n = IDLE;
      end else begin
        cnt_n = cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_INIT;
      grant_q <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      data_q  <= data_n;
      last_q  <= last_n;
      lock_q  <= lock_n;
      ptr_q   <= ptr_n;
`ifdef LCD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_n;
      terr_q  <= terr_n;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Purpose: self-checking bench for lcd_write_arbiter (directed table, corner sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_write_arbiter;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TO       = 16;
  localparam int LONG_DLY = 10;
`else
  localparam int TO       = 4096;
  localparam int LONG_DLY = 100;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [7:0] req_data0 = '0;
  logic [7:0] req_data1 = '0;
  logic [1:0] req_last = '0;
  logic [1:0] grant;
  logic [1:0] ack;
  logic       initDone = 1'b0;
  logic       writeStart;
  logic [7:0] dataIn;
  logic       writeDone = 1'b0;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  lcd_write_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .req_last    (req_last),
    .grant       (grant),
    .ack         (ack),
    .initDone    (initDone),
    .writeStart  (writeStart),
    .dataIn      (dataIn),
    .writeDone   (writeDone),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; writeDone = 1'b0; initDone = 1'b0;
    tick; tick;
    chk("rst grant", grant, 2'b00);
    chk("rst ack", ack, 2'b00);
    chk("rst writeStart", writeStart, 1'b0);
    chk("rst dataIn", dataIn, 8'h00);
    chk("rst timeout_err", timeout_err, 1'b0);
    rst = 1'b0; initDone = 1'b1;
    tick;
    initDone = 1'b0;
  endtask

  // Precondition: current cycle is IDLE with inputs set. Ends in the ACK cycle.
  task automatic serve_byte(input string tag, input logic [1:0] eg, input logic [7:0] ed, input int d);
    int bad;
    bad = 0;
    tick;
    chk({tag, " writeStart"}, writeStart, 1'b1);
    chk({tag, " grant"}, grant, eg);
    chk({tag, " dataIn"}, dataIn, ed);
    writeDone = 1'b1;
    tick;
    writeDone = 1'b0;
    chk({tag, " early writeDone ignored"}, ack, 2'b00);
    for (int i = 0; i < d; i++) begin
      if (writeStart !== 1'b0 || dataIn !== ed || ack !== 2'b00 || grant !== eg) bad++;
      tick;
    end
    writeDone = 1'b1;
    tick;
    writeDone = 1'b0;
    chk({tag, " busy stable"}, bad, 0);
    chk({tag, " ack"}, ack, eg);
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] eg;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[6];

  // Random-phase reference model state.
  int  seq[2], pos[2], blen[2];
  bit  lock_m;
  int  owner_m;
  int  last_served_m;

  function automatic int elig(input logic [1:0] v);
    if (lock_m) return v[owner_m] ? owner_m : -1;
    if (v == 2'b11) return 1 - last_served_m;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  function automatic logic [7:0] head(input int r);
    return {(r == 1), 7'(seq[r])};
  endfunction

  function automatic logic [1:0] onehot(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  initial begin
    int ws_cnt, bad, ws_win;
    bit outstanding, ack_pend, ws_pend, was_ack, was_ws;
    int busy_cyc;
    logic [1:0] vdrv;

    tbl[0] = '{2'b11, 8'h41, 8'h42, 2'b01, 8'h41};
    tbl[1] = '{2'b11, 8'h41, 8'h42, 2'b10, 8'h42};
    tbl[2] = '{2'b10, 8'h51, 8'h52, 2'b10, 8'h52};
    tbl[3] = '{2'b11, 8'h61, 8'h62, 2'b01, 8'h61};
    tbl[4] = '{2'b01, 8'h71, 8'h72, 2'b01, 8'h71};
    tbl[5] = '{2'b11, 8'h81, 8'h82, 2'b10, 8'h82};

    // Init gating: no write while initDone stays low.
    rst = 1'b1; tick; tick; rst = 1'b0;
    req_valid = 2'b01; req_data0 = 8'h30; req_last = 2'b11;
    ws_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (writeStart !== 1'b0) ws_cnt++;
    end
    chk("no write before init", ws_cnt, 0);
    initDone = 1'b1;
    tick;
    initDone = 1'b0;
    chk("init idle writeStart", writeStart, 1'b0);
    serve_byte("init", 2'b01, 8'h30, 0);
    req_valid = 2'b00;
    tick;

    // Round-robin table of single-byte bursts from a fresh reset.
    do_reset;
    foreach (tbl[k]) begin
      req_valid = tbl[k].valid; req_data0 = tbl[k].d0; req_data1 = tbl[k].d1; req_last = 2'b11;
      serve_byte($sformatf("tbl%0d", k), tbl[k].eg, tbl[k].ed, 2);
      req_valid = 2'b00;
      tick;
      chk($sformatf("tbl%0d ack one-shot", k), ack, 2'b00);
      chk($sformatf("tbl%0d grant released", k), grant, 2'b00);
    end

    // Three-byte burst from requester 0 while requester 1 waits.
    req_valid = 2'b11; req_data0 = "A"; req_data1 = "Z"; req_last = 2'b10;
    serve_byte("burstA", 2'b01, "A", 1);
    req_data0 = "B"; req_valid = 2'b10;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (writeStart !== 1'b0 || grant !== 2'b01) bad++;
    end
    chk("lock holds with owner idle", bad, 0);
    req_valid = 2'b11;
    serve_byte("burstB", 2'b01, "B", 1);
    req_data0 = "C"; req_last = 2'b11;
    tick;
    chk("burst lock grant", grant, 2'b01);
    serve_byte("burstC", 2'b01, "C", 1);
    req_valid = 2'b10;
    tick;
    chk("burst end grant", grant, 2'b00);
    serve_byte("after burst", 2'b10, "Z", 0);
    req_valid = 2'b00;
    tick;

    // Long writeDone delay.
    req_valid = 2'b01; req_data0 = 8'h55; req_last = 2'b11;
    serve_byte("long", 2'b01, 8'h55, LONG_DLY);
    req_valid = 2'b00;
    tick;
    chk("long ack one-shot", ack, 2'b00);

    // Reset during BUSY: no ack for the in-flight byte, pointer back to requester 0.
    req_valid = 2'b10; req_data1 = 8'h66;
    tick; tick;
    rst = 1'b1;
    tick;
    chk("midrst grant", grant, 2'b00);
    chk("midrst ack", ack, 2'b00);
    chk("midrst writeStart", writeStart, 1'b0);
    chk("midrst dataIn", dataIn, 8'h00);
    rst = 1'b0; writeDone = 1'b1; req_valid = 2'b00;
    tick;
    writeDone = 1'b0;
    chk("midrst no ack", ack, 2'b00);
    initDone = 1'b1;
    tick;
    initDone = 1'b0;
    req_valid = 2'b11; req_data0 = 8'h77; req_data1 = 8'h78; req_last = 2'b11;
    serve_byte("post rst prio", 2'b01, 8'h77, 0);
    req_valid = 2'b00;
    tick;

`ifdef LCD_ARB_TIMEOUT_EN
    // Watchdog: requester 1 wins (0 served last), writeDone never comes.
    req_valid = 2'b11; req_data0 = 8'h90; req_data1 = 8'h91; req_last = 2'b11;
    tick;
    chk("to issue grant", grant, 2'b10);
    tick;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (timeout_err !== 1'b0 || ack !== 2'b00) bad++;
      tick;
    end
    chk("to not early", bad + int'(timeout_err), 0);
    tick;
    chk("to err", timeout_err, 1'b1);
    chk("to grant", grant, 2'b00);
    chk("to ack", ack, 2'b00);
    tick;
    chk("to next writeStart", writeStart, 1'b1);
    chk("to next grant", grant, 2'b01);
    chk("to next dataIn", dataIn, 8'h90);
    tick;
    writeDone = 1'b1;
    tick;
    writeDone = 1'b0;
    chk("to next ack", ack, 2'b01);
    req_valid = 2'b00;
    tick;
    chk("to sticky", timeout_err, 1'b1);
`else
    chk("timeout_err tied low", timeout_err, 1'b0);
`endif

    // Random traffic against the transaction-level model.
    do_reset;
    for (int r = 0; r < 2; r++) begin
      seq[r] = 0; pos[r] = 0; blen[r] = $urandom_range(3, 1);
    end
    lock_m = 1'b0; owner_m = 0; last_served_m = 1;
    outstanding = 1'b0; ack_pend = 1'b0; busy_cyc = 0;
    vdrv = 2'($urandom);
    req_valid = vdrv;
    req_data0 = head(0); req_data1 = head(1);
    req_last = {pos[1] == blen[1] - 1, pos[0] == blen[0] - 1};
    ws_win = elig(vdrv);
    ws_pend = (ws_win >= 0);
    for (int c = 0; c < 4000; c++) begin
      tick;
      was_ack = ack_pend; was_ws = ws_pend;
      chk("rnd ack", ack, ack_pend ? onehot(owner_m) : 2'b00);
      chk("rnd writeStart", writeStart, ws_pend);
      if (ws_pend) begin
        chk("rnd issue grant", grant, onehot(ws_win));
        chk("rnd issue dataIn", dataIn, head(ws_win));
      end else if (outstanding) begin
        chk("rnd hold dataIn", dataIn, head(owner_m));
        chk("rnd hold grant", grant, onehot(owner_m));
      end else if (!was_ack) begin
        chk("rnd idle grant", grant, lock_m ? onehot(owner_m) : 2'b00);
      end
      if (ack_pend) begin
        seq[owner_m]++;
        if (pos[owner_m] == blen[owner_m] - 1) begin
          lock_m = 1'b0; last_served_m = owner_m;
          pos[owner_m] = 0; blen[owner_m] = $urandom_range(3, 1);
        end else begin
          lock_m = 1'b1; pos[owner_m]++;
        end
        outstanding = 1'b0; ack_pend = 1'b0;
      end
      if (ws_pend) begin
        outstanding = 1'b1; owner_m = ws_win; busy_cyc = 0; ws_pend = 1'b0;
      end
      vdrv = {($urandom % 4) != 0, ($urandom % 4) != 0};
      req_valid = vdrv;
      req_data0 = head(0); req_data1 = head(1);
      req_last = {pos[1] == blen[1] - 1, pos[0] == blen[0] - 1};
      if (outstanding && !was_ws) begin
        writeDone = (($urandom % 3) == 0) || (busy_cyc >= 8);
        busy_cyc++;
      end else begin
        writeDone = (($urandom % 5) == 0);
      end
      ack_pend = outstanding && !was_ws && writeDone;
      ws_win = elig(vdrv);
      ws_pend = !outstanding && !was_ack && (ws_win >= 0);
    end
    req_valid = 2'b00; writeDone = 1'b0;
    chk("rnd traffic flowed", int'(seq[0] > 50 && seq[1] > 50), 1);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, sets the writeDone watchdog limit in clk cycles (used only with LCD_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester character-valid flag.
REQ-005 req_data0 / req_data1  input  8 each  character or command byte from requester 0 / 1.
REQ-006 req_last  input  2  marks the final byte of a requester's burst.
REQ-007 grant  output  2  one-hot owner of the LCD write path (00 = none).
REQ-008 ack  output  2  one-cycle pulse when the requester's byte has completed.
REQ-009 initDone  input  1  LCD controller power-on init complete.
REQ-010 writeStart  output  1  one-cycle start pulse to the LCD controller.
REQ-011 dataIn  output  8  byte to the LCD controller, held stable from writeStart until writeDone.
REQ-012 writeDone  input  1  LCD controller byte-complete pulse.
REQ-013 timeout_err  output  1  sticky watchdog flag, cleared only by rst (tied 0 without LCD_ARB_TIMEOUT_EN).

Function
REQ-014 The arbiter SHALL use five states: WAIT_INIT, IDLE, ISSUE, BUSY and ACK.
REQ-015 WAIT_INIT SHALL move to IDLE on the first cycle initDone=1; initDone SHALL be ignored afterwards.
REQ-016 In IDLE with no lock and any req_valid=1, the arbiter SHALL pick a winner by round-robin, defined as follows:
  - if both requesters are valid, the one not served last wins;
  - after reset, requester 0 has priority.
REQ-017 When a winner is picked, the next edge SHALL register grant, dataIn=req_dataX and the last flag, and enter ISSUE.
REQ-018 ISSUE SHALL last exactly one cycle with writeStart=1, then go to BUSY with writeStart=0.
REQ-019 In BUSY, writeDone=1 SHALL move the arbiter to ACK, where ack[owner]=1 for exactly one cycle.
REQ-020 In ACK with last=1, the next edge SHALL clear grant, clear the lock, flip the round-robin pointer and enter IDLE.
REQ-021 In ACK with last=0, the next edge SHALL set the lock, keep grant and enter IDLE.
REQ-022 In IDLE while locked, only the granted requester's req_valid SHALL be sampled; the other requester waits regardless of its valid.
REQ-023 Latency: from req_valid sampled in IDLE to writeStart SHALL be 1 cycle; from writeDone to ack SHALL be 1 cycle.
REQ-024 req_valid/req_data SHALL NOT be sampled during ISSUE, BUSY or ACK, so a requester can advance its data on ack.
REQ-025 A writeDone outside BUSY SHALL be ignored.
REQ-026 req_valid dropping mid-burst SHALL keep the lock and grant indefinitely (without LCD_ARB_TIMEOUT_EN).

Reset
REQ-027 rst SHALL force state=WAIT_INIT, grant=00, ack=00, writeStart=0, dataIn=8'h00, lock=0, rr pointer=requester 0 and timeout_err=0.
REQ-028 rst asserted mid-operation (ISSUE, BUSY or ACK) SHALL take effect on the next edge; the in-flight byte SHALL get no ack.

Configuration
REQ-029 With macro LCD_ARB_TIMEOUT_EN defined, a counter SHALL run during the locked IDLE and BUSY states, reloading on each state change.
REQ-030 When that counter reaches TIMEOUT_CYC, the arbiter SHALL:
  - set timeout_err;
  - clear grant and the lock;
  - flip the rr pointer;
  - enter IDLE without an ack.
REQ-031 Without LCD_ARB_TIMEOUT_EN, no counter SHALL be built and timeout_err SHALL be constant 0.

Structure
REQ-032 A shared package lcd_arb_pkg SHALL hold:
  - the state enumeration;
  - NREQ=2;
  - the default TIMEOUT_CYC.
REQ-033 The round-robin pick SHALL be a sub-module lcd_rr_pick with inputs valid[1:0], ptr and lock/owner, and output a one-hot winner; everything else SHALL stay in lcd_write_arbiter.

Verification
REQ-034 Scenario: hold initDone=0 for 20 cycles with req_valid=01 -> writeStart stays 0; raise initDone -> grant=01 and writeStart pulses 1 cycle later.
REQ-035 Scenario: both requesters valid after reset, each a 1-byte burst with last=1, req_data0=8'h41, req_data1=8'h42 -> dataIn is 8'h41 then 8'h42, and grant goes 01 then 10.
REQ-036 Scenario: requester 0 sends a 3-byte burst "ABC" while requester 1 is valid throughout -> grant stays 01 for all 3 acks, then moves to 10.
REQ-037 Scenario: writeDone delayed 100 cycles -> dataIn stable and writeStart low throughout BUSY; ack pulses exactly once.
REQ-038 Scenario: rst raised during BUSY -> next cycle all outputs are at reset values and no ack is issued.
REQ-039 Scenario (LCD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): no writeDone -> after 16 BUSY cycles, timeout_err=1, grant=00, and the other requester is served next.
